// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the board reset sequencer.
// Covers the sequencer state encoding, reset-cause codes and counter width.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_LOCK   = 2'd1,
    CAUSE_SWITCH = 2'd2,
    CAUSE_SOFT   = 2'd3
  } cause_e;

  // Wide enough to count 0 .. max-1 for the largest of the three periods.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchroniser followed by a consecutive-cycle debouncer.
// With DEBOUNCE_CYCLES = 1 it degenerates to a synchroniser plus one qualify flop.
module sync_debounce
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_level
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, 1, 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   w_sync_out;

  // Bit 0 is the metastability catcher; only the last stage is consumed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync_out == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= w_sync_out;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: merges PLL lock, debounced switch and software request,
// stretches the reset, then releases NUM_OUTPUTS domains in order (bit 0 first).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUTPUTS     = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STRETCH_CYCLES  = 16,
  parameter int RELEASE_GAP     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_locked,
  input  logic                   io_resetSwitch,
  input  logic                   io_softReset,
  output logic [NUM_OUTPUTS-1:0] io_resetOut,
  output logic                   io_busy,
  output logic [1:0]             io_cause
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, STRETCH_CYCLES, RELEASE_GAP);
  localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'((NUM_OUTPUTS > 1) ? NUM_OUTPUTS - 2 : 0);
  localparam logic [NUM_OUTPUTS-1:0] ALL_ON = '1;

  seq_state_e             r_state;
  seq_state_e             w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_next;
  logic [NUM_OUTPUTS-1:0] r_out;
  logic [NUM_OUTPUTS-1:0] w_out_next;
  logic                   r_busy;
  cause_e                 r_cause;
  cause_e                 w_cause_next;
  cause_e                 w_req_cause;

  logic w_locked;
  logic w_switch;
  logic w_req;
  logic w_reassert;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(1)
  ) u_lock_sync (
    .clock  (clock),
    .reset  (reset),
    .i_async(io_locked),
    .o_level(w_locked)
  );

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_db (
    .clock  (clock),
    .reset  (reset),
    .i_async(io_resetSwitch),
    .o_level(w_switch)
  );

  assign w_req      = !w_locked | w_switch | io_softReset;
  assign w_reassert = (r_state != ASSERT) && w_req;

  // Later assignments win, giving LOCK > SWITCH > SOFT.
  always_comb begin
    w_req_cause = CAUSE_SOFT;
    if (w_switch)  w_req_cause = CAUSE_SWITCH;
    if (!w_locked) w_req_cause = CAUSE_LOCK;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_out   <= ALL_ON;
      r_busy  <= 1'b1;
      r_cause <= CAUSE_POR;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_out   <= w_out_next;
      r_busy  <= |w_out_next;
      r_cause <= w_cause_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ASSERT: begin
        if (!w_req) w_state_next = STRETCH;
      end
      STRETCH: begin
        if (w_req) begin
          w_state_next = ASSERT;
        end else if (r_cnt == STRETCH_LAST) begin
          w_state_next = (NUM_OUTPUTS == 1) ? RUN : RELEASE;
        end
      end
      RELEASE: begin
        if (w_req) begin
          w_state_next = ASSERT;
        end else if ((r_cnt == GAP_LAST) && (r_idx == IDX_LAST)) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_req) w_state_next = ASSERT;
      end
      default: w_state_next = ASSERT;
    endcase
  end

  // Outputs form a thermometer code, so each release is a left shift by one.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_out_next   = r_out;
    w_cause_next = r_cause;
    if (w_reassert) begin
      w_cnt_next   = '0;
      w_idx_next   = '0;
      w_out_next   = ALL_ON;
      w_cause_next = w_req_cause;
    end else begin
      case (r_state)
        ASSERT: begin
          w_cnt_next = '0;
          w_idx_next = '0;
          w_out_next = ALL_ON;
        end
        STRETCH: begin
          if (r_cnt == STRETCH_LAST) begin
            w_cnt_next = '0;
            w_idx_next = '0;
            w_out_next = r_out << 1;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_next = '0;
            w_idx_next = r_idx + IDX_W'(1);
            w_out_next = r_out << 1;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          w_out_next = '0;
        end
        default: begin
          w_out_next = ALL_ON;
        end
      endcase
    end
  end

  assign io_resetOut = r_out;
  assign io_busy     = r_busy;
  assign io_cause    = r_cause;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised board reset controller that replaces the single-flop switch/PLL-lock reset with a complete sequencer. It merges PLL lock, a debounced push-switch and a software reset request from the debug access port into one request. It stretches the reset and releases NUM_OUTPUTS reset domains in order, with a fixed gap between them. It sits directly after the clock wizard in the top level and drives the reset of every downstream block; it also reports the cause of the last reset.

Parameters:
NUM_OUTPUTS, 2, number of sequenced reset outputs (1..8)
SYNC_STAGES, 2, synchroniser depth for asynchronous inputs (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before the switch state is accepted (10 ms at 100 MHz; >=1)
STRETCH_CYCLES, 16, cycles reset is held after all requests drop (>=1)
RELEASE_GAP, 8, cycles between successive output releases (>=1)

Ports:
clock  in  1  system clock (clock-wizard output)
reset  in  1  synchronous, active-high reset (power-on/global)
io_locked  in  1  PLL lock, asynchronous
io_resetSwitch  in  1  board switch, asynchronous, high = reset request
io_softReset  in  1  software reset request, synchronous to clock; a single-cycle pulse is sufficient
io_resetOut  out  NUM_OUTPUTS  per-domain resets, active-high, registered; bit 0 is released first
io_busy  out  1  high whenever any io_resetOut bit is high
io_cause  out  2  cause of the most recent reset: 0 POR, 1 LOCK, 2 SWITCH, 3 SOFT

Behaviour:
- reset (synchronous, active-high):
  - all io_resetOut = 1, io_busy = 1, io_cause = 0.
  - state = ASSERT; all counters = 0; synchroniser flops = 0; debounced switch = 0.
- Synchronisers:
  - io_locked and io_resetSwitch each pass through SYNC_STAGES flops.
  - io_softReset is used unsynchronised.
- Debounce:
  - The debounced switch value changes only after the synchronised switch has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle where the input equals the debounced value clears the counter.
- Request: req = !locked_sync | switch_db | io_softReset.
- States:
  - ASSERT: all outputs 1. On req low -> STRETCH with cnt = 0. Stays in ASSERT while req is high.
  - STRETCH: cnt increments each cycle. At cnt == STRETCH_CYCLES-1 -> RELEASE with idx = 0, and io_resetOut[0] is cleared on that same edge.
  - RELEASE: a gap counter runs for RELEASE_GAP cycles, then clears io_resetOut[idx+1]. After clearing bit NUM_OUTPUTS-1 -> RUN.
  - RUN: all outputs 0, io_busy = 0.
- Request during STRETCH, RELEASE or RUN:
  - On the next edge: state -> ASSERT, all io_resetOut = 1, counters cleared.
  - Partially released domains are re-asserted together; no ordering on assertion.
- io_cause is latched on every entry to ASSERT. Priority: LOCK > SWITCH > SOFT. It is held until the next entry.
- Timing example: io_softReset sampled high at edge t.
  - Outputs are high after t; req is low at edge t+1 -> STRETCH.
  - io_resetOut[0] falls at edge t+STRETCH_CYCLES+1.
  - io_resetOut[k] falls RELEASE_GAP edges after bit k-1.
- Simultaneous sources: causes are ORed into req; release starts only when all sources are clear.
- NUM_OUTPUTS = 1: RELEASE exits to RUN on the same edge bit 0 clears; no gap.
- io_busy = OR of io_resetOut. It is registered with the outputs, so there is no extra latency.

Decomposition:
- Package reset_seq_pkg:
  - state enum: ASSERT, STRETCH, RELEASE, RUN.
  - cause codes: CAUSE_POR, CAUSE_LOCK, CAUSE_SWITCH, CAUSE_SOFT.
  - counter width function: clog2 of max(DEBOUNCE_CYCLES, STRETCH_CYCLES, RELEASE_GAP).
- Sub-module sync_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES):
  - Instantiated for io_resetSwitch.
  - io_locked uses it with DEBOUNCE_CYCLES = 1, i.e. synchroniser plus a one-cycle qualify.

Test Plan (bench parameters: NUM_OUTPUTS=3, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=16, RELEASE_GAP=8):
1. Power-on: reset high 5 cycles, io_locked = 1, then reset low -> io_resetOut = 3'b111 until bit 0 falls, then bit 1 falls 8 edges later and bit 2 8 edges after that. io_cause = 0; io_busy falls with bit 2.
2. In RUN, 1-cycle io_softReset at edge t -> io_resetOut = 3'b111 after t; bit 0 falls at t+17, bit 1 at t+25, bit 2 at t+33; io_cause = 3.
3. In RUN, io_resetSwitch high for 3 cycles, then low -> no change in io_resetOut. Held high 10 cycles -> all outputs assert; io_cause = 2.
4. io_locked drops during RELEASE (bit 0 already 0) -> all bits 1 on the next edge after synchronisation. Release does not restart until io_locked returns high; io_cause = 1.
5. io_locked low together with io_softReset pulse -> io_cause = 1 (priority check).
6. reset asserted mid-RELEASE -> outputs 3'b111, io_cause = 0 on the next edge; the full sequence then repeats.
